// File: rtl/ps2_rx_framer.sv
// PS/2 device-to-host receiver: synchronizes the PS/2 lines, frames
// start/8 data/odd parity/stop, and reports good bytes, errors and timeouts.
module ps2_rx_framer #(
  parameter int   TIMEOUT_CYCLES = 50000,
  parameter logic SYNC_INIT      = 1'b1
) (
  input  logic       clk,
  input  logic       i_sclr,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_err,
  output logic       o_busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          prev_clk;
  logic          sync_clk;
  logic          sync_dat;
  logic          fall;
  logic          timeout;
  logic [2:0]    count;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tcnt;

  assign sync_clk = clk_sync[1];
  assign sync_dat = dat_sync[1];
  assign fall     = prev_clk & ~sync_clk;
  // A fall in the terminal-count cycle wins over the timeout.
  assign timeout  = (state != IDLE) && (tcnt == TW'(TIMEOUT_CYCLES - 1)) && !fall;

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      clk_sync <= {SYNC_INIT, SYNC_INIT};
      dat_sync <= {SYNC_INIT, SYNC_INIT};
      prev_clk <= SYNC_INIT;
    end else begin
      clk_sync <= {clk_sync[0], i_ps2_clk};
      dat_sync <= {dat_sync[0], i_ps2_dat};
      prev_clk <= sync_clk;
    end
  end

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      state   <= IDLE;
      count   <= 3'd0;
      tcnt    <= '0;
      shreg   <= 8'h00;
      par     <= 1'b0;
      o_data  <= 8'h00;
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      if (state == IDLE || fall || timeout) tcnt <= '0;
      else                                  tcnt <= tcnt + 1'b1;

      if (timeout) begin
        state  <= IDLE;
        o_busy <= 1'b0;
        o_err  <= 1'b1;
      end else if (fall) begin
        case (state)
          IDLE: begin
            // A high start bit is ignored; wait for the next fall.
            if (!sync_dat) begin
              state  <= DATA;
              count  <= 3'd0;
              o_busy <= 1'b1;
            end
          end
          DATA: begin
            shreg <= {sync_dat, shreg[7:1]};
            count <= count + 3'd1;
            if (count == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= sync_dat;
            state <= STOP;
          end
          STOP: begin
            if (sync_dat && ((^shreg) ^ par)) begin
              o_data  <= shreg;
              o_valid <= 1'b1;
            end else begin
              o_err <= 1'b1;
            end
            state  <= IDLE;
            o_busy <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx_framer.sv
// Self-checking bench for ps2_rx_framer: table of frames, random frames
// against a frame-level model, and hand sequences for timeout/reset corners.
module tb_ps2_rx_framer;
  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       i_sclr = 1'b1;
  logic       i_ps2_clk = 1'b1;
  logic       i_ps2_dat = 1'b1;
  logic [7:0] o_data;
  logic       o_valid, o_err, o_busy;

  ps2_rx_framer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .i_sclr(i_sclr), .i_ps2_clk(i_ps2_clk), .i_ps2_dat(i_ps2_dat),
    .o_data(o_data), .o_valid(o_valid), .o_err(o_err), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    bit         busy;
    int         cyc;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    bit         par_bad;
    bit         stop;
    bit         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  ev_t  ev_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic prev_v = 1'b0, prev_e = 1'b0;
  int   last_fall = 0;
  int   stop_fall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse monitor: records each valid/err pulse with its cycle stamp.
  always @(negedge clk) begin
    if (mon_en && (o_valid === 1'b1 || o_err === 1'b1)) begin
      check("excl", {31'b0, o_valid & o_err}, 0);
      check("width", {31'b0, (o_valid & prev_v) | (o_err & prev_e)}, 0);
      ev_q.push_back('{is_err: o_err, data: o_data, busy: o_busy, cyc: cyc});
    end
    prev_v = o_valid;
    prev_e = o_err;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    i_ps2_dat = b;
    tick(4);
    i_ps2_clk = 1'b0;
    last_fall = cyc;
    tick(8);
    i_ps2_clk = 1'b1;
    tick(4);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_bad, input bit stop);
    bit p;
    p = (($countones(d) % 2) == 0) ^ par_bad;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(stop);
    stop_fall = last_fall;
  endtask

  task automatic expect_ev(input string name, input bit is_err, input logic [7:0] d, input int ecyc);
    ev_t e;
    if (ev_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no pulse seen, expected %s", name, is_err ? "err" : "valid");
    end else begin
      e = ev_q.pop_front();
      check({name, "_kind"}, {31'b0, e.is_err}, {31'b0, is_err});
      if (!is_err) check({name, "_data"}, {24'b0, e.data}, {24'b0, d});
      check({name, "_lat"}, e.cyc, ecyc);
    end
  endtask

  task automatic expect_none(input string name);
    check({name, "_extra"}, ev_q.size(), 0);
    ev_q.delete();
  endtask

  vec_t vecs[7];
  logic [7:0] model_data;

  initial begin
    vecs[0] = '{8'h1C, 1'b1, 1'b1, 1'b1, 8'h00};  // parity error after reset
    vecs[1] = '{8'h1C, 1'b0, 1'b1, 1'b0, 8'h1C};  // good 0x1C
    vecs[2] = '{8'hF0, 1'b0, 1'b0, 1'b1, 8'h1C};  // parity bit 1, stop 0
    vecs[3] = '{8'hF0, 1'b0, 1'b1, 1'b0, 8'hF0};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[5] = '{8'hFF, 1'b0, 1'b1, 1'b0, 8'hFF};
    vecs[6] = '{8'hA5, 1'b0, 1'b0, 1'b1, 8'hFF};

    tick(4);
    i_sclr = 1'b0;
    mon_en = 1'b1;
    tick(1);
    check("rst_data", {24'b0, o_data}, 0);
    check("rst_valid", {31'b0, o_valid}, 0);
    check("rst_err", {31'b0, o_err}, 0);
    check("rst_busy", {31'b0, o_busy}, 0);
    tick(5);

    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].data, vecs[i].par_bad, vecs[i].stop);
      expect_ev($sformatf("vec%0d", i), vecs[i].exp_err, vecs[i].exp_data, stop_fall + 3);
      check($sformatf("vec%0d_odata", i), {24'b0, o_data}, {24'b0, vecs[i].exp_data});
      check($sformatf("vec%0d_busy", i), {31'b0, o_busy}, 0);
      expect_none($sformatf("vec%0d", i));
      tick(20);
    end

    // Random frames against a frame-level model.
    model_data = 8'hFF;
    for (int n = 0; n < 20; n++) begin
      logic [7:0] d;
      int kind;
      d = 8'($urandom);
      kind = $urandom_range(0, 2);
      send_frame(d, kind == 1, kind != 2);
      if (kind == 0) model_data = d;
      expect_ev($sformatf("rnd%0d", n), kind != 0, d, stop_fall + 3);
      check($sformatf("rnd%0d_odata", n), {24'b0, o_data}, {24'b0, model_data});
      expect_none($sformatf("rnd%0d", n));
      tick($urandom_range(1, 30));
    end

    // Timeout after 4 data bits of 0x1C.
    send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    begin
      int t0;
      t0 = last_fall;
      check("to_busy_mid", {31'b0, o_busy}, 1);
      for (int k = 0; k < 300 && ev_q.size() == 0; k++) tick(1);
      tick(1);
      if (ev_q.size() != 0) check("to_busy_at_err", {31'b0, ev_q[0].busy}, 0);
      expect_ev("timeout", 1'b1, 8'h00, t0 + 3 + TO);
      check("to_odata", {24'b0, o_data}, {24'b0, model_data});
    end
    expect_none("timeout");
    tick(10);
    send_frame(8'h1C, 1'b0, 1'b1);
    expect_ev("after_to", 1'b0, 8'h1C, stop_fall + 3);
    expect_none("after_to");
    tick(10);

    // Reset mid-frame after 5 data bits.
    send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    check("midrst_busy_pre", {31'b0, o_busy}, 1);
    i_sclr = 1'b1;
    tick(1);
    i_sclr = 1'b0;
    tick(2);
    check("midrst_busy", {31'b0, o_busy}, 0);
    check("midrst_odata", {24'b0, o_data}, 0);
    tick(TO + 20);
    expect_none("midrst");
    send_frame(8'hF0, 1'b0, 1'b1);
    expect_ev("after_rst", 1'b0, 8'hF0, stop_fall + 3);
    expect_none("after_rst");
    tick(10);

    // Back-to-back frames with no gap.
    begin
      int s1;
      send_frame(8'hF0, 1'b0, 1'b1);
      s1 = stop_fall;
      send_frame(8'h1C, 1'b0, 1'b1);
      expect_ev("b2b0", 1'b0, 8'hF0, s1 + 3);
      expect_ev("b2b1", 1'b0, 8'h1C, stop_fall + 3);
      expect_none("b2b");
    end
    tick(10);

    // A high start bit is ignored.
    i_ps2_dat = 1'b1;
    tick(4);
    i_ps2_clk = 1'b0;
    tick(8);
    i_ps2_clk = 1'b1;
    tick(2);
    check("badstart_busy", {31'b0, o_busy}, 0);
    tick(TO + 20);
    expect_none("badstart");

    // PS/2 clock already low (start bit) when reset releases.
    i_sclr = 1'b1;
    i_ps2_dat = 1'b0;
    i_ps2_clk = 1'b0;
    tick(3);
    i_sclr = 1'b0;
    tick(5);
    check("rel_low_busy", {31'b0, o_busy}, 1);
    i_ps2_clk = 1'b1;
    tick(4);
    for (int i = 0; i < 8; i++) send_bit(logic'((8'h1C >> i) & 8'h01));
    send_bit(1'b0);
    send_bit(1'b1);
    expect_ev("rel_low", 1'b0, 8'h1C, last_fall + 3);
    expect_none("rel_low");

    tick(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
